// File: rtl/branch_resolver.sv
// Conditional-branch resolver: evaluates the br* condition on Ra, forms the target PC
// and pulses a one-cycle PC load. Optional statistics counters under BRANCH_STATS_EN.
module branch_resolver #(
  parameter int DATA_W   = 32,
  parameter int OFFSET_W = 19,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [31:0]       ir,
  input  logic [DATA_W-1:0] ra_value,
  input  logic [DATA_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_next,
  output logic [CNT_W-1:0]  taken_count,
  output logic [CNT_W-1:0]  total_count
);

  typedef enum logic [1:0] {IDLE, EVAL, RESOLVE, DONE} state_t;

  typedef struct packed {
    logic [1:0]          cond;
    logic [OFFSET_W-1:0] offset;
    logic [DATA_W-1:0]   ra;
    logic [DATA_W-1:0]   pc;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q;
  logic              accept;
  logic              flag_q, flag_d;
  logic [DATA_W-1:0] target;
  logic              unused_ir;

  assign unused_ir = ^{ir[31:21]};
  assign busy      = (state_q != IDLE);

  // The DONE state takes a new start on its closing edge, giving one branch per 3 cycles.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE:    if (start) begin accept = 1'b1; state_d = EVAL; end
      EVAL:    state_d = RESOLVE;
      RESOLVE: state_d = DONE;
      DONE:    if (start) begin accept = 1'b1; state_d = EVAL; end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flag_d = 1'b0;
    case (req_q.cond)
      2'b00: flag_d = (req_q.ra == '0);
      2'b01: flag_d = (req_q.ra != '0);
      2'b10: flag_d = ~req_q.ra[DATA_W-1];
      2'b11: flag_d =  req_q.ra[DATA_W-1];
      default: flag_d = 1'b0;
    endcase
  end

  assign target = req_q.pc + {{(DATA_W-OFFSET_W){req_q.offset[OFFSET_W-1]}}, req_q.offset};

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      req_q   <= '0;
      flag_q  <= 1'b0;
      done    <= 1'b0;
      taken   <= 1'b0;
      pc_load <= 1'b0;
      pc_next <= '0;
    end else begin
      state_q <= state_d;
      if (accept)             req_q  <= {ir[20:19], ir[OFFSET_W-1:0], ra_value, pc};
      if (state_q == EVAL)    flag_q <= flag_d;
      done    <= (state_q == RESOLVE);
      taken   <= (state_q == RESOLVE) & flag_q;
      pc_load <= (state_q == RESOLVE) & flag_q;
      if (state_q == RESOLVE) pc_next <= flag_q ? target : req_q.pc;
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating counters; updated in the cycle the done pulse is visible.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      taken_count <= '0;
      total_count <= '0;
    end else if (done) begin
      if (total_count != {CNT_W{1'b1}})         total_count <= total_count + CNT_W'(1);
      if (taken && taken_count != {CNT_W{1'b1}}) taken_count <= taken_count + CNT_W'(1);
    end
  end
`else
  assign taken_count = '0;
  assign total_count = '0;
`endif

endmodule
